// File: rtl/indeser_pkg.sv
// Shared types and default constants for the serial-to-parallel word aligner.
package indeser_pkg;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam logic [15:0] DEF_SYNC_PATTERN = 16'h00A5;
  localparam int unsigned DEF_LOCK_COUNT   = 4;
  localparam int unsigned SLIP_W           = 8;
  localparam int unsigned MATCH_W          = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/indeser_slip_ctr.sv
// Bit-position counter; a slip parks the count at zero for one extra edge,
// which pushes the next word boundary one bit later.
module indeser_slip_ctr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic slip,
  output logic boundary_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic             hold;

  assign boundary_c = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hold <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      hold <= 1'b0;
    end else if (slip) begin
      cnt  <= '0;
      hold <= 1'b1;
    end else if (hold) begin
      hold <= 1'b0;
    end else if (boundary_c) begin
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/input_deser_align.sv
// Serial-to-parallel input stage with training-pattern word alignment.
// Optional saturating slip counter on SLIP_CNT when INDESER_SLIPCNT_EN is defined.
module input_deser_align
  import indeser_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC_PATTERN),
  parameter int unsigned      LOCK_COUNT   = DEF_LOCK_COUNT
) (
  input  logic              SCLK,
  input  logic              RSTN,
  input  logic              D,
  input  logic              REALIGN,
  output logic [WIDTH-1:0]  WORD,
  output logic              WVALID,
  output logic              LOCKED,
  output logic [SLIP_W-1:0] SLIP_CNT
);

  logic [WIDTH-2:0]   sr;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   word_d;
  logic [MATCH_W-1:0] match, match_d;
  state_e             state, state_d;
  logic               boundary_c;
  logic               slip_c;
  logic               wvalid_d;

  assign cand = {sr, D};

  indeser_slip_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk        (SCLK),
    .rst_n      (RSTN),
    .clear      (REALIGN),
    .slip       (slip_c),
    .boundary_c (boundary_c)
  );

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= ST_SEARCH;
      match  <= '0;
      sr     <= '0;
      WORD   <= '0;
      WVALID <= 1'b0;
      LOCKED <= 1'b0;
    end else begin
      state  <= state_d;
      match  <= match_d;
      sr     <= {sr[WIDTH-3:0], D};
      WORD   <= word_d;
      WVALID <= wvalid_d;
      LOCKED <= (state_d == ST_LOCKED);
    end
  end

  // Alignment decisions happen only at word boundaries; REALIGN overrides all.
  always_comb begin
    state_d = state;
    match_d = match;
    slip_c  = 1'b0;
    if (REALIGN) begin
      state_d = ST_SEARCH;
      match_d = '0;
    end else if (boundary_c) begin
      unique case (state)
        ST_SEARCH: begin
          if (cand == SYNC_PATTERN) begin
            match_d = MATCH_W'(1);
            state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end else begin
            slip_c = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (cand == SYNC_PATTERN) begin
            match_d = match + 1'b1;
            if (match_d == MATCH_W'(LOCK_COUNT)) state_d = ST_LOCKED;
          end else begin
            match_d = '0;
            slip_c  = 1'b1;
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_SEARCH;
      endcase
    end
  end

  // The locking boundary itself delivers a word.
  always_comb begin
    wvalid_d = boundary_c && !REALIGN && (state_d == ST_LOCKED);
    word_d   = wvalid_d ? cand : WORD;
  end

`ifdef INDESER_SLIPCNT_EN
  logic [SLIP_W-1:0] slip_cnt;

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      slip_cnt <= '0;
    end else if (slip_c && (slip_cnt != '1)) begin
      slip_cnt <= slip_cnt + 1'b1;
    end
  end

  assign SLIP_CNT = slip_cnt;
`else
  assign SLIP_CNT = '0;
`endif

endmodule

// File: tb/tb_input_deser_align.sv
// Directed table-driven bench for input_deser_align (WIDTH=8, SYNC=A5, LOCK_COUNT=4).
module tb_input_deser_align;

`ifdef INDESER_SLIPCNT_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif

  logic       SCLK;
  logic       RSTN;
  logic       D;
  logic       REALIGN;
  logic [7:0] WORD;
  logic       WVALID;
  logic       LOCKED;
  logic [7:0] SLIP_CNT;

  input_deser_align #(
    .WIDTH        (8),
    .SYNC_PATTERN (8'hA5),
    .LOCK_COUNT   (4)
  ) dut (
    .SCLK     (SCLK),
    .RSTN     (RSTN),
    .D        (D),
    .REALIGN  (REALIGN),
    .WORD     (WORD),
    .WVALID   (WVALID),
    .LOCKED   (LOCKED),
    .SLIP_CNT (SLIP_CNT)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  typedef struct {
    bit         rst;
    int         nbits;
    logic [7:0] data;
    bit         rl;
    logic       wv;
    logic [7:0] word;
    logic       lk;
    int         slips;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(bit rst, int n, logic [7:0] d, bit rl,
                              logic wv, logic [7:0] w, logic lk, int sl);
    vec_t v;
    v = '{rst, n, d, rl, wv, w, lk, sl};
    tbl.push_back(v);
  endfunction

  // Four aligned A5 words: no output until the fourth boundary locks.
  function automatic void add_lock(logic [7:0] prev_word, int sl);
    for (int k = 0; k < 3; k++) add(0, 8, 8'hA5, 0, 0, prev_word, 0, sl);
    add(0, 8, 8'hA5, 0, 1, 8'hA5, 1, sl);
  endfunction

  task automatic send_bit(input logic b, input logic rl);
    D       = b;
    REALIGN = rl;
    @(posedge SCLK);
    #1;
    REALIGN = 1'b0;
  endtask

  task automatic do_reset();
    RSTN    = 1'b0;
    D       = 1'b0;
    REALIGN = 1'b0;
    repeat (2) @(posedge SCLK);
    #1;
    chk("reset WORD", 32'(WORD), 32'h0);
    chk("reset WVALID", 32'(WVALID), 32'h0);
    chk("reset LOCKED", 32'(LOCKED), 32'h0);
    chk("reset SLIP_CNT", 32'(SLIP_CNT), 32'h0);
    RSTN = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [7:0] a5;
    RSTN    = 1'b0;
    D       = 1'b0;
    REALIGN = 1'b0;
    a5      = 8'hA5;

    // Aligned training from release, then locked payload.
    add(1, 8, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8, 8'hA5, 0, 1, 8'hA5, 1, 0);
    add(0, 8, 8'hA5, 0, 1, 8'hA5, 1, 0);
    add(0, 8, 8'hA5, 0, 1, 8'hA5, 1, 0);
    add(0, 8, 8'h3C, 0, 1, 8'h3C, 1, 0);
    add(0, 8, 8'hFF, 0, 1, 8'hFF, 1, 0);
    add(0, 8, 8'h00, 0, 1, 8'h00, 1, 0);

    // Two matches then 5A: back to SEARCH with one slip; one pad bit re-phases.
    add(1, 8, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8, 8'h5A, 0, 0, 8'h00, 0, 1);
    add(0, 1, 8'h00, 0, 0, 8'h00, 0, 1);
    add_lock(8'h00, 1);

    // Five zero bits: first boundary lands 3 bits into the pattern, 5 slips to align.
    add(1, 5, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 8, 8'hA5, 0, 0, 8'h00, 0, k);
    add_lock(8'h00, 5);
    add(0, 8, 8'hA5, 0, 1, 8'hA5, 1, 5);

    // REALIGN on a locked boundary: no strobe, SLIP_CNT kept, count restarts at 0.
    add(0, 8, 8'hA5, 1, 0, 8'hA5, 0, 5);
    add_lock(8'hA5, 5);

    // REALIGN mid-word must also clear the bit counter.
    add(0, 3, 8'h05, 1, 0, 8'hA5, 0, 5);
    add_lock(8'hA5, 5);

    foreach (tbl[i]) begin
      v = tbl[i];
      if (v.rst) do_reset();
      for (int b = v.nbits - 1; b >= 0; b--) begin
        send_bit(v.data[b], v.rl && (b == 0));
        if (b != 0) chk($sformatf("rec%0d bit%0d WVALID", i, b), 32'(WVALID), 32'h0);
      end
      chk($sformatf("rec%0d WVALID", i), 32'(WVALID), 32'(v.wv));
      chk($sformatf("rec%0d WORD", i), 32'(WORD), 32'(v.word));
      chk($sformatf("rec%0d LOCKED", i), 32'(LOCKED), 32'(v.lk));
      chk($sformatf("rec%0d SLIP_CNT", i), 32'(SLIP_CNT), SLIP_EN ? 32'(v.slips) : 32'h0);
    end

    // Asynchronous reset three bits into a locked word.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("pre-rst LOCKED", 32'(LOCKED), 32'h1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("async WORD", 32'(WORD), 32'h0);
    chk("async WVALID", 32'(WVALID), 32'h0);
    chk("async LOCKED", 32'(LOCKED), 32'h0);
    chk("async SLIP_CNT", 32'(SLIP_CNT), 32'h0);
    @(posedge SCLK);
    #1;
    RSTN = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      for (int b = 7; b >= 0; b--) send_bit(a5[b], 1'b0);
      chk($sformatf("relock w%0d LOCKED", w), 32'(LOCKED), (w == 4) ? 32'h1 : 32'h0);
      chk($sformatf("relock w%0d WVALID", w), 32'(WVALID), (w == 4) ? 32'h1 : 32'h0);
      chk($sformatf("relock w%0d WORD", w), 32'(WORD), (w == 4) ? 32'hA5 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
